// File: rtl/muldiv_hilo_pkg.sv
// rtl/muldiv_hilo_pkg.sv - shared encodings and defaults for the HI/LO multiply/divide unit
package muldiv_hilo_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - iterative shift-add multiply / restoring divide datapath on unsigned magnitudes
module muldiv_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;

    // acc_lo holds the multiplier (mul) or the dividend being shifted out (div); m holds the other operand
    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
        trial    = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, m_q};
        if (load_i) begin
            acc_hi_d = '0;
            acc_lo_d = a_i;
            m_d      = b_i;
            cnt_d    = CNT_W'(WIDTH - 1);
        end else if (step_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (div_i) begin
                if (!trial[WIDTH]) begin
                    acc_hi_d = trial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_o   = (cnt_q == '0);
    assign acc_hi_o = acc_hi_q;
    assign acc_lo_o = acc_lo_q;

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle multiply/divide unit owning the architectural HI/LO registers
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             sx_q, sx_d, sy_q, sy_d, yz_q, yz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] x_q, x_d, hi_q, hi_d, lo_q, lo_d;

    logic             load, core_last, run_div;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             in_signed, in_div, sx_in, sy_in;
    logic [WIDTH-1:0] mag_x, mag_y;
    logic [2*WIDTH-1:0] prod;

    assign in_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign in_div    = op_i[1];
    assign sx_in     = in_signed & x_i[WIDTH-1];
    assign sy_in     = in_signed & y_i[WIDTH-1];
    assign mag_x     = sx_in ? -x_i : x_i;
    assign mag_y     = sy_in ? -y_i : y_i;
    assign run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);

    muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (load),
        .step_i   (state_q == CALC),
        .div_i    (run_div),
        .a_i      (in_div ? mag_x : mag_y),
        .b_i      (in_div ? mag_y : mag_x),
        .last_o   (core_last),
        .acc_hi_o (core_hi),
        .acc_lo_o (core_lo)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        yz_d    = yz_q;
        x_d     = x_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        prod    = {core_hi, core_lo};
        unique case (state_q)
            IDLE: begin
                if (mthi_i) hi_d = x_i;
                if (mtlo_i) lo_d = x_i;
                if (start_i) begin
                    load    = 1'b1;
                    state_d = CALC;
                    op_d    = op_e'(op_i);
                    x_d     = x_i;
                    sx_d    = sx_in;
                    sy_d    = sy_in;
                    yz_d    = (y_i == '0);
                end
            end
            CALC: begin
                if (core_last) state_d = FIX;
            end
            FIX: begin
                // Core works on magnitudes; signs are restored here in one step
                if (run_div) begin
                    if (yz_q) begin
                        lo_d = '1;
                        hi_d = x_q;
                    end else begin
                        lo_d = (sx_q ^ sy_q) ? -core_lo : core_lo;
                        hi_d = sx_q ? -core_hi : core_hi;
                    end
                end else begin
                    if ((op_q == OP_MULT) && (sx_q ^ sy_q)) prod = -prod;
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            yz_q    <= 1'b0;
            x_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            yz_q    <= yz_d;
            x_q     <= x_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Replaces the single-cycle `x*y` and `x/y`, `x%y` paths of the combinational ALU.
- Sits on the write side of HI/LO: consumes rs/rt operands from the execute stage and produces the HI/LO values that mfhi/mflo read.
- Drives `busy` to the hazard unit so the pipeline stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- x  in  WIDTH  rs operand (multiplicand / dividend)
- y  in  WIDTH  rt operand (multiplier / divisor)
- mthi  in  1  write x into HI
- mtlo  in  1  write x into LO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse after HI/LO are updated by an operation

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on a clock edge with start=1. At that edge the unit latches op, x, y and the operand signs; signed ops latch operand magnitudes.
  - CALC iterates exactly WIDTH cycles; the counter runs from WIDTH-1 down to 0.
    - Multiply: shift-add, one multiplier bit per cycle, building a 2*WIDTH product.
    - Divide: restoring, one quotient bit per cycle.
  - CALC -> FIX when the counter reaches 0.
  - FIX writes hi/lo, then -> IDLE. done=1 for the cycle following the FIX edge.
- Latency: with start sampled at edge E, hi/lo update at edge E+WIDTH+1 (E+33 for the default), and done is high during the cycle after that edge.
- busy = (state != IDLE). It is registered and goes high in the cycle after the start edge.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product. For MULT, the product is negated when sign(x) XOR sign(y) is set.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (y=0, any signedness): still takes full latency; lo=0xFFFFFFFF, hi=x as latched.
- start while busy: ignored. The in-flight operation is unaffected and no error is raised; the hazard unit must not issue.
- mthi/mtlo:
  - Take effect on the next edge, in IDLE only; ignored while busy.
  - mthi and mtlo may both be asserted together.
  - In IDLE, a simultaneous start is also accepted; the later FIX overwrites both registers.
- done never asserts for mthi/mtlo.
- Operand inputs may change freely after the start edge; only latched copies are used.
- Reset asserted mid-operation: aborts immediately to reset values with no partial HI/LO update.
- back-to-back: start may be asserted in the same cycle done is high (state is IDLE); it is accepted.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3.
  - State encodings: IDLE, CALC, FIX.
  - WIDTH default.
- One natural sub-module, muldiv_core: the iterative shift-add/restoring datapath (accumulator, counter, step logic).
- muldiv_hilo keeps the FSM, sign handling, HI/LO registers and the mthi/mtlo path.

Test Plan:
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF, start at edge E -> busy high from E+1; at E+33 hi=0xFFFFFFFE, lo=0x00000001; done pulses one cycle.
- MULT x=0xFFFFFFF9 (-7), y=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV x=-7, y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU x=100, y=0 -> after 33 cycles lo=0xFFFFFFFF, hi=100. DIV x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7, then at cycle 5 assert start (MULT 2*3) and mthi x=0xDEAD -> both ignored; final hi=2, lo=14; exactly one done.
- In IDLE assert mthi x=0x11111111 and mtlo in consecutive cycles -> hi=0x11111111, then lo updated; busy and done stay 0.
- Start MULTU 5*6, pull rst_n low at cycle 10 for a half cycle -> hi=lo=0, busy=0 immediately; a new MULTU 5*6 then completes with lo=30 after 33 cycles.
